// File: rtl/pid_pwm_pkg.sv
// Shared widths, duty type and the control-effort clamp for the PID PWM output stage.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package pid_pwm_pkg;

    localparam int PWM_CTRL_W = 16;
    localparam int PWM_CNT_W  = 10;
    localparam int PWM_DT_W   = 6;

    typedef logic [PWM_CNT_W:0] duty_t;

    // Largest duty the default counter can express: 100% of a maximum-length period.
    localparam duty_t DUTY_FULL = duty_t'(1 << PWM_CNT_W);

    // top is period+1; callers narrow the result to their own duty width.
    function automatic logic [31:0] sat_duty(input logic signed [31:0] u,
                                             input logic [31:0]        top);
        logic signed [31:0] top_s;
        top_s = signed'(top);
        if (u <= 0)
            sat_duty = '0;
        else if (u >= top_s)
            sat_duty = top;
        else
            sat_duty = unsigned'(u);
    endfunction

    function automatic logic is_clamped(input logic signed [31:0] u,
                                        input logic [31:0]        top);
        is_clamped = (u < 0) || (u > signed'(top));
    endfunction

endpackage

// File: rtl/pid_pwm_deadtime.sv
// Complementary gate driver with dead time inserted on every raw PWM edge.
// Latency: 1 cycle from raw_next to gates, plus dead_time cycles after each edge.
// Backpressure: none; free-running every cycle.
module pid_pwm_deadtime #(
    parameter int DT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            raw_next,
    input  logic [DT_W-1:0] dead_time,
    output logic            pwm_h,
    output logic            pwm_l
);

    logic            raw_q, raw_d;
    logic            en_q, en_d;
    logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;

    always_comb begin
        raw_d    = raw_next;
        en_d     = en;
        dt_cnt_d = dt_cnt_q;
        // A restart after enable is treated like an edge so the low side also gets a guard gap.
        if ((raw_next != raw_q) || (en && !en_q))
            dt_cnt_d = dead_time;
        else if (dt_cnt_q != '0)
            dt_cnt_d = dt_cnt_q - DT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q    <= 1'b0;
            en_q     <= 1'b0;
            dt_cnt_q <= '0;
        end else begin
            raw_q    <= raw_d;
            en_q     <= en_d;
            dt_cnt_q <= dt_cnt_d;
        end
    end

    assign pwm_h = raw_q & (dt_cnt_q == '0);
    assign pwm_l = ~raw_q & en_q & (dt_cnt_q == '0);

endmodule

// File: rtl/pid_pwm_out.sv
// PID output stage: clamps control effort, double-buffers duty per period, drives gated PWM pair.
// Latency: sample applies at the next period wrap; gates lag the counter by 1 cycle.
// Backpressure: u_ready drops while a sample is pending and reopens in the wrap cycle.
module pid_pwm_out
    import pid_pwm_pkg::*;
#(
    parameter int CTRL_W = PWM_CTRL_W,
    parameter int CNT_W  = PWM_CNT_W,
    parameter int DT_W   = PWM_DT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic        [CNT_W-1:0]  period,
    input  logic        [DT_W-1:0]   dead_time,
    input  logic                     u_valid,
    input  logic signed [CTRL_W-1:0] u_data,
    output logic                     u_ready,
    output logic                     pwm_h,
    output logic                     pwm_l,
    output logic                     sync_o,
    output logic                     sat_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_active_q, period_active_d;
    logic [CNT_W:0]   duty_shadow_q, duty_shadow_d;
    logic [CNT_W:0]   duty_active_q, duty_active_d;
    logic             pending_q, pending_d;
    logic             sat_q, sat_d;
    logic             sync_q, sync_d;

    logic [31:0]      top_ext;
    logic [CNT_W:0]   duty_in;
    logic             sat_in;
    logic             wrap;
    logic             load;
    logic             hs;
    logic             raw_next;

    assign top_ext  = 32'(period_active_q) + 32'd1;
    assign duty_in  = (CNT_W+1)'(sat_duty(32'(u_data), top_ext));
    assign sat_in   = is_clamped(32'(u_data), top_ext);

    assign wrap     = en & (cnt_q == period_active_q);
    // While halted the active registers track their inputs, so every cycle acts as a load point.
    assign load     = wrap | ~en;
    assign u_ready  = ~pending_q | load;
    assign hs       = u_valid & u_ready;
    assign raw_next = en & ({1'b0, cnt_q} < duty_active_q);

    always_comb begin
        cnt_d           = cnt_q;
        period_active_d = period_active_q;
        duty_shadow_d   = duty_shadow_q;
        duty_active_d   = duty_active_q;
        pending_d       = pending_q;
        sat_d           = sat_q;
        sync_d          = en & (cnt_q == '0);

        if (hs) begin
            duty_shadow_d = duty_in;
            sat_d         = sat_in;
            pending_d     = 1'b1;
        end

        if (load) begin
            cnt_d           = '0;
            period_active_d = period;
            // Newest sample wins over one that was already waiting in the shadow.
            if (hs) begin
                duty_active_d = duty_in;
                pending_d     = 1'b0;
            end else if (pending_q) begin
                duty_active_d = duty_shadow_q;
                pending_d     = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q           <= '0;
            period_active_q <= '0;
            duty_shadow_q   <= '0;
            duty_active_q   <= '0;
            pending_q       <= 1'b0;
            sat_q           <= 1'b0;
            sync_q          <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            period_active_q <= period_active_d;
            duty_shadow_q   <= duty_shadow_d;
            duty_active_q   <= duty_active_d;
            pending_q       <= pending_d;
            sat_q           <= sat_d;
            sync_q          <= sync_d;
        end
    end

    assign sync_o = sync_q;
    assign sat_o  = sat_q;

    pid_pwm_deadtime #(
        .DT_W (DT_W)
    ) u_deadtime (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .raw_next  (raw_next),
        .dead_time (dead_time),
        .pwm_h     (pwm_h),
        .pwm_l     (pwm_l)
    );

endmodule

// File: tb/tb_pid_pwm_out.sv
// Scoreboard bench: stimulus queues per-period expectations, a monitor checks each period window.
module tb_pid_pwm_out;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic [9:0]         period;
    logic [5:0]         dead_time;
    logic               u_valid;
    logic signed [15:0] u_data;
    logic               u_ready;
    logic               pwm_h;
    logic               pwm_l;
    logic               sync_o;
    logic               sat_o;

    pid_pwm_out dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .period    (period),
        .dead_time (dead_time),
        .u_valid   (u_valid),
        .u_data    (u_data),
        .u_ready   (u_ready),
        .pwm_h     (pwm_h),
        .pwm_l     (pwm_l),
        .sync_o    (sync_o),
        .sat_o     (sat_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int    len;
        int    h;
        int    l;
        int    sat;
        string name;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   armed;
    int   w_len, w_h, w_l, w_ovl;
    int   tests_run;
    int   failed;

    task automatic check(input string name, input int act, input int req);
        tests_run++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One window = sync_o cycle up to (not including) the next sync_o cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            armed = 1'b0;
            w_len = 0; w_h = 0; w_l = 0; w_ovl = 0;
        end else begin
            if (sync_o) begin
                if (armed) begin
                    check({cur.name, "_len"}, w_len, cur.len);
                    check({cur.name, "_h"}, w_h, cur.h);
                    check({cur.name, "_l"}, w_l, cur.l);
                    check({cur.name, "_sat"}, int'(sat_o), cur.sat);
                    check({cur.name, "_overlap"}, w_ovl, 0);
                end
                armed = 1'b0;
                if (exp_q.size() > 0) begin
                    cur   = exp_q.pop_front();
                    armed = 1'b1;
                end
                w_len = 0; w_h = 0; w_l = 0; w_ovl = 0;
            end
            w_len++;
            w_h += int'(pwm_h);
            w_l += int'(pwm_l);
            if (pwm_h && pwm_l) w_ovl = 1;
        end
    end

    task automatic send(input int v, output int nwait);
        @(negedge clk);
        u_valid = 1'b1;
        u_data  = 16'(v);
        nwait   = 0;
        while (!u_ready && nwait < 100) begin
            @(negedge clk);
            nwait++;
        end
        if (nwait >= 100) check("send_timeout", nwait, 0);
        @(posedge clk);
        #1 u_valid = 1'b0;
    endtask

    task automatic wait_sync(input int k);
        int seen = 0;
        int n    = 0;
        while (seen < k && n < 200) begin
            @(negedge clk);
            n++;
            if (sync_o) seen++;
        end
        if (seen < k) check("sync_timeout", seen, k);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || armed) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", n, 0);
    endtask

    task automatic expect_periods(input int len, input int h, input int l, input int sat,
                                  input string name);
        exp_q.push_back('{len, h, l, sat, {name, "_p1"}});
        exp_q.push_back('{len, h, l, sat, {name, "_p2"}});
        drain();
    endtask

    initial begin
        int nw;
        int hcount;
        int found;
        tests_run = 0;
        failed    = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        period    = 10'd9;
        dead_time = 6'd0;
        u_valid   = 1'b0;
        u_data    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pwm_h", int'(pwm_h), 0);
        check("rst_pwm_l", int'(pwm_l), 0);
        check("rst_sync", int'(sync_o), 0);
        check("rst_sat", int'(sat_o), 0);
        check("rst_u_ready", int'(u_ready), 1);
        #1 rst_n = 1'b1;

        // Basic duty
        @(negedge clk);
        en = 1'b1;
        send(4, nw);
        wait_sync(2);
        expect_periods(10, 4, 6, 0, "basic");

        // Saturation both ways
        send(-5, nw);
        wait_sync(2);
        expect_periods(10, 0, 10, 1, "sat_neg");
        send(200, nw);
        wait_sync(2);
        expect_periods(10, 10, 0, 1, "sat_pos");

        // Dead time
        dead_time = 6'd2;
        send(5, nw);
        wait_sync(2);
        expect_periods(10, 3, 3, 0, "dt_u5");
        send(1, nw);
        wait_sync(2);
        expect_periods(10, 0, 7, 0, "dt_u1");

        // Back-pressure: pending 3 is overtaken by 7 accepted in the wrap cycle
        dead_time = 6'd0;
        wait_sync(2);
        repeat (3) @(negedge clk);
        send(3, nw);
        check("bp_first_wait", nw, 0);
        @(negedge clk);
        check("bp_ready_low", int'(u_ready), 0);
        send(7, nw);
        exp_q.push_back('{10, 7, 3, 0, "bp_u7"});
        check("bp_waited", int'(nw > 0), 1);
        @(negedge clk);
        check("bp_sync_a", int'(sync_o), 0);
        @(negedge clk);
        check("bp_sync_b", int'(sync_o), 1);
        drain();

        // Enable low, period change, restart with dead time
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("dis_pwm_h", int'(pwm_h), 0);
        check("dis_pwm_l", int'(pwm_l), 0);
        check("dis_u_ready", int'(u_ready), 1);
        period    = 10'd4;
        dead_time = 6'd2;
        repeat (2) @(negedge clk);
        send(2, nw);
        check("dis_accept_wait", nw, 0);
        repeat (2) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("en_sync", int'(sync_o), 1);
        check("en_gap1", int'(pwm_h | pwm_l), 0);
        @(negedge clk);
        check("en_gap2", int'(pwm_h | pwm_l), 0);
        dead_time = 6'd0;
        wait_sync(2);
        expect_periods(5, 2, 3, 0, "p5_u2");

        // Asynchronous reset while the high side is on
        period = 10'd9;
        send(5, nw);
        wait_sync(3);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(negedge clk);
            if (pwm_h) found = 1;
        end
        check("arst_saw_high", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pwm_h", int'(pwm_h), 0);
        check("arst_pwm_l", int'(pwm_l), 0);
        check("arst_sync", int'(sync_o), 0);
        check("arst_u_ready", int'(u_ready), 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        hcount = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            hcount += int'(pwm_h);
        end
        check("post_rst_no_high", hcount, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
